// File: rtl/l1_dcache_if.sv
// Pipeline-side request/response and memory-side block transfer signals of
// the L1 data cache, bundled so the cache and its environment share one port.
interface l1_dcache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  // cache side
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  // pipeline + memory side
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache, 4 words per line.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | serving hits; a miss stalls and picks WRITEBACK or ALLOCATE
// WRITEBACK | dirty victim line is being written to memory
// ALLOCATE  | requested line is being fetched from memory
module l1_dcache #(
  parameter int IDX_W = 3
) (
  input logic        i_clk,
  input logic        rst_n,
  l1_dcache_if.slave bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag_in;
  logic             req, hit, fill_done;
  logic [31:0]      sel_word;
  logic [127:0]     merged_line;

  assign off       = bus.proc_addr[1:0];
  assign idx       = bus.proc_addr[IDX_W+1:2];
  assign tag_in    = bus.proc_addr[29:IDX_W+2];
  assign req       = bus.proc_read | bus.proc_write;
  assign hit       = req & valid_q[idx] & (tag_q[idx] == tag_in);
  assign fill_done = (state_q == ALLOCATE) & bus.mem_ready;
  assign sel_word  = data_q[idx][{off, 5'b0} +: 32];

  // store data merged into the selected word of the indexed line
  always_comb begin
    merged_line = data_q[idx];
    merged_line[{off, 5'b0} +: 32] = bus.proc_wdata;
  end

  // state register; reset aborts any miss in flight
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req && !hit)
                   state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (bus.mem_ready) state_d = ALLOCATE;
      ALLOCATE:  if (bus.mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // outputs decoded from the registered state; everything zero unless qualified
  always_comb begin
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        bus.proc_stall = req & ~hit;
        if (hit && !bus.proc_write) bus.proc_rdata = sel_word;
      end
      WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {tag_q[idx], idx};
        bus.mem_wdata  = data_q[idx];
      end
      ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = bus.proc_addr[29:2];
      end
      default: ;
    endcase
  end

  // line status bits; reset invalidates everything and drops dirty data
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (state_q == IDLE && hit && bus.proc_write) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // tag and data storage: line fill from memory or store-hit word merge
  always_ff @(posedge i_clk) begin
    if (fill_done) begin
      data_q[idx] <= bus.mem_rdata;
      tag_q[idx]  <= tag_in;
    end else if (state_q == IDLE && hit && bus.proc_write) begin
      data_q[idx] <= merged_line;
    end
  end
endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: hit vectors from a table, miss sequences by hand.
module tb_l1_dcache;
  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  l1_dcache_if bus ();

  l1_dcache #(.IDX_W(3)) dut (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        stall;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wdata);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
  endtask

  // Full miss: IDLE cycle, wb_n WRITEBACK cycles, rd_n ALLOCATE cycles, then the hit.
  task automatic miss_seq(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wdata,
                          input int wb_n, input logic [27:0] wb_addr, input logic [127:0] wb_data,
                          input int rd_n, input logic [27:0] rd_addr, input logic [127:0] fill,
                          input logic [31:0] exp_rdata);
    int stalls = 0;
    @(posedge i_clk); #1;
    drive(rd, wr, addr, wdata);
    #1;
    chk("miss_idle_stall", 128'(bus.proc_stall), 128'(1));
    chk("miss_idle_mem", {126'(0), bus.mem_read, bus.mem_write}, 128'(0));
    if (bus.proc_stall) stalls++;
    for (int i = 0; i < wb_n; i++) begin
      @(posedge i_clk); #1;
      bus.mem_ready = (i == wb_n - 1);
      bus.mem_rdata = '1;
      #1;
      chk("wb_mem_write", 128'(bus.mem_write), 128'(1));
      chk("wb_mem_read", 128'(bus.mem_read), 128'(0));
      chk("wb_mem_addr", 128'(bus.mem_addr), 128'(wb_addr));
      chk("wb_mem_wdata", bus.mem_wdata, wb_data);
      if (bus.proc_stall) stalls++;
    end
    for (int i = 0; i < rd_n; i++) begin
      @(posedge i_clk); #1;
      bus.mem_ready = (i == rd_n - 1);
      bus.mem_rdata = fill;
      #1;
      chk("alloc_mem_read", 128'(bus.mem_read), 128'(1));
      chk("alloc_mem_write", 128'(bus.mem_write), 128'(0));
      chk("alloc_mem_addr", 128'(bus.mem_addr), 128'(rd_addr));
      chk("alloc_mem_wdata", bus.mem_wdata, 128'(0));
      if (bus.proc_stall) stalls++;
    end
    @(posedge i_clk); #1;
    bus.mem_ready = 1'b0;
    #1;
    chk("replay_stall", 128'(bus.proc_stall), 128'(0));
    chk("replay_mem", {100'(0), bus.mem_addr, bus.mem_read, bus.mem_write}, 128'(0));
    chk("replay_rdata", 128'(bus.proc_rdata), 128'((rd && !wr) ? exp_rdata : 32'h0));
    chk("stall_cycles", 128'(stalls), 128'(wb_n + rd_n + 1));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'h22222222};
    vecs[1] = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b0, 1'b0, 32'h11110000};
    vecs[2] = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b1, 1'b0, 32'h33333333};
    vecs[3] = '{1'b0, 1'b1, 30'h11, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 30'h12, 32'h55555555, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'h55555555};
    vecs[8] = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b0, 1'b0, 32'h33333333};

    drive(1'b0, 1'b0, 30'h0, 32'h0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #3;
    chk("rst_stall", 128'(bus.proc_stall), 128'(0));
    chk("rst_rdata", 128'(bus.proc_rdata), 128'(0));
    chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
    repeat (2) @(posedge i_clk);
    #1 rst_n = 1'b1;

    // clean read miss, memory answers in the third ALLOCATE cycle
    miss_seq(1'b1, 1'b0, 30'h11, 32'h0,
             0, 28'h0, 128'h0,
             3, 28'h4, {32'h33333333, 32'h22222222, 32'h12345678, 32'h11110000},
             32'h12345678);
    // the hit just returned the old word1; overwrite via vectors below
    vecs[4].rdata = 32'hDEADBEEF;

    for (int i = 0; i < 9; i++) begin
      @(posedge i_clk); #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      bus.mem_ready = vecs[i].rdy;
      bus.mem_rdata = '1;
      #1;
      chk($sformatf("vec%0d_stall", i), 128'(bus.proc_stall), 128'(vecs[i].stall));
      chk($sformatf("vec%0d_rdata", i), 128'(bus.proc_rdata), 128'(vecs[i].rdata));
      chk($sformatf("vec%0d_mem", i),
          {100'(0), bus.mem_addr, bus.mem_read, bus.mem_write}, 128'(0));
    end
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    bus.mem_ready = 1'b0;

    // dirty conflict on index 4: writeback old line, then fetch block 0xC
    miss_seq(1'b1, 1'b0, 30'h31, 32'h0,
             2, 28'h4, {32'h33333333, 32'h55555555, 32'hDEADBEEF, 32'h11110000},
             2, 28'hC, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0},
             32'hC1C1C1C1);
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 30'h0, 32'h0);

    // write miss to an invalid line: allocate only, then merge
    miss_seq(1'b0, 1'b1, 30'h40, 32'hA5A5A5A5,
             0, 28'h0, 128'h0,
             1, 28'h10, {32'h40000003, 32'h40000002, 32'h40000001, 32'h40000000},
             32'h0);
    @(posedge i_clk); #1;
    drive(1'b1, 1'b0, 30'h40, 32'h0);
    #1;
    chk("wmerge_stall", 128'(bus.proc_stall), 128'(0));
    chk("wmerge_rdata", 128'(bus.proc_rdata), 128'(32'hA5A5A5A5));

    // conflicting miss on index 0 writes back the merged word
    miss_seq(1'b1, 1'b0, 30'h00, 32'h0,
             1, 28'h10, {32'h40000003, 32'h40000002, 32'h40000001, 32'hA5A5A5A5},
             1, 28'h0, {32'h0A000003, 32'h0A000002, 32'h0A000001, 32'h0A000000},
             32'h0A000000);

    // dirty line 4, then reset while its writeback is in progress
    @(posedge i_clk); #1;
    drive(1'b0, 1'b1, 30'h31, 32'h77777777);
    #1;
    chk("wr31_stall", 128'(bus.proc_stall), 128'(0));
    @(posedge i_clk); #1;
    drive(1'b1, 1'b0, 30'h11, 32'h0);
    #1;
    chk("rstwb_idle_stall", 128'(bus.proc_stall), 128'(1));
    @(posedge i_clk); #1;
    #1;
    chk("rstwb_in_wb", 128'(bus.mem_write), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rstwb_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rstwb_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rstwb_mem_addr", 128'(bus.mem_addr), 128'(0));
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    @(posedge i_clk); #1;
    rst_n = 1'b1;

    // line 4 was invalidated, so this is a clean fetch
    miss_seq(1'b1, 1'b0, 30'h31, 32'h0,
             0, 28'h0, 128'h0,
             1, 28'hC, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0},
             32'hD1D1D1D1);
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    repeat (2) @(posedge i_clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache sitting directly below the five-stage MIPS pipeline's MEM stage. It consumes the pipeline's word-addressed DCACHE request (read/write enable, 30-bit word address, write data), returns read data, and holds the pipeline with `proc_stall` while a miss is serviced. On a miss it talks to main memory over a 128-bit block interface with a ready handshake. The block is parameterised by line count; each line holds 4 words.

## Interface
Parameters:
- IDX_W, 3, index bits; the cache has 2^IDX_W lines. Tag width is TAG_W = 28-IDX_W.

Ports:
- Reset is rst_n, asynchronous, active-low; the clock is i_clk.
- i_clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- proc_read  in  1  load request, held stable while stalled.
- proc_write  in  1  store request, held stable while stalled.
- proc_addr  in  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  in  32  store data.
- proc_stall  out  1  high while the current request cannot complete this cycle.
- proc_rdata  out  32  load data, valid when proc_read=1 and proc_stall=0.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block writeback request.
- mem_addr  out  28  block address ({tag,index}).
- mem_wdata  out  128  writeback line, word k on bits [32k+31:32k].
- mem_ready  in  1  one-cycle pulse: the current memory request has completed.
- mem_rdata  in  128  fetched line, same word packing; valid with mem_ready.

## Operation
- Per line state: valid, dirty, tag[TAG_W-1:0], data[127:0]. On reset, every valid and dirty bit is cleared. Data and tags are don't-care.
- Request = proc_read | proc_write. If both are high, it is treated as a write.
- hit = request & valid[idx] & (tag[idx] == proc_addr tag).
- FSM states are IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - No request: proc_stall=0 and nothing changes.
  - Read hit: proc_stall=0 and proc_rdata = the selected word, combinationally.
  - Write hit: proc_stall=0. At the edge, the selected word is replaced by proc_wdata and dirty[idx] is set to 1.
  - Miss: proc_stall=1. At the edge, go to WRITEBACK if valid[idx] & dirty[idx], else go to ALLOCATE.
- WRITEBACK:
  - proc_stall=1, mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx].
  - Outputs are held until mem_ready. On the mem_ready edge, go to ALLOCATE.
- ALLOCATE:
  - proc_stall=1, mem_read=1, mem_addr=proc_addr[29:2].
  - On the mem_ready edge: data[idx]=mem_rdata, tag updated, valid=1, dirty=0, go to IDLE.
- The replayed request then hits in IDLE: a read returns its data, and a write merges its word and sets dirty.
- Output values outside their qualifying cases:
  - proc_rdata = 0 unless there is a read hit.
  - mem_wdata = 0 unless mem_write=1.
  - mem_addr = 0 in IDLE.
- mem_read and mem_write are never high together. Both are registered-state decodes (glitch-free).

## Timing
- Reset values: proc_stall=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, state=IDLE.
- Hit: zero added latency, same-cycle completion.
- Clean miss: 1 IDLE cycle + N ALLOCATE cycles, where mem_ready arrives in the Nth. Then 1 IDLE hit cycle with stall low, giving total stall N+1 cycles.
- Dirty miss: 1 IDLE cycle + W WRITEBACK cycles + R ALLOCATE cycles, giving total stall W+R+1 cycles.
- Memory request handshake: the request is valid from the cycle it is asserted until the mem_ready cycle inclusive. It drops, or switches to the next request, on the following cycle.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Reset asserted mid-miss aborts immediately (asynchronously):
  - mem_read and mem_write drop.
  - All lines are invalidated; dirty data is lost by design.
  - The state returns to IDLE.
- proc_addr/proc_wdata changing during a stall is a protocol violation and has undefined behaviour.

## Test plan
- Reset, then read proc_addr=0x0000011 with memory ready after 3 cycles, mem_rdata word1=0x12345678.
  - Required: mem_read with mem_addr=0x0000004 for 3 cycles.
  - Required: proc_stall high for 4 cycles, then low with proc_rdata=0x12345678. No mem_write.
- Read 0x0000012 (same block) right after: proc_stall=0 the same cycle, word2 returned, no memory traffic.
- Write 0x0000011 with 0xDEADBEEF (hit): stall 0. A following read of 0x0000011 returns 0xDEADBEEF, and the line is dirty.
- Read 0x0000031, which has the same index (4) and a different tag:
  - First, a mem_write with mem_addr=0x0000004 and mem_wdata[63:32]=0xDEADBEEF.
  - After mem_ready, a mem_read with mem_addr=0x000000C.
  - Finally, the data is returned with stall low.
- Write miss to a clean invalid line, 0x0000040 with 0xA5A5A5A5:
  - Required: allocate only (no mem_write), then the write merges.
  - A later conflicting miss on index 0 writes back 0xA5A5A5A5 in word 0.
- Assert rst_n low during WRITEBACK: mem_write falls in the same cycle. After release, a read of 0x0000031 misses and issues mem_read, not mem_write.
